// File: rtl/sram_burst_ctrl_if.sv
// Request, write-data and read-data channels between a bus master and sram_burst_ctrl.
interface sram_burst_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [BE_WIDTH-1:0]   req_be;
  logic                  req_err;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_be, wr_valid, wr_data, rd_ready,
    input  req_ready, req_err, wr_ready, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_be, wr_valid, wr_data, rd_ready,
    output req_ready, req_err, wr_ready, rd_valid, rd_data, rd_last, busy
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Single-port SRAM burst controller: one read or write burst at a time, registered read path
// with backpressure, byte-enabled writes and a burst address that wraps at MEM_SIZE.
module sram_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1 << ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input logic               clk,
  input logic               reset,
  sram_burst_ctrl_if.slave  bus
);
  localparam int unsigned               BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0]     ADDR_LAST  = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]       ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic [ADDR_WIDTH-1:0] addr, addr_inc;
  logic [LEN_WIDTH-1:0]  len, cnt;
  logic [BE_WIDTH-1:0]   be;

  logic                  req_ready_q, req_err_q, wr_ready_q, busy_q, rd_valid_q, rd_last_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  req_ready_nxt, req_err_nxt, wr_ready_nxt, busy_nxt, rd_valid_nxt, rd_last_nxt;

  logic addr_ok, req_fire, req_take, wr_fire, rd_fire, fetch, final_beat;

  assign bus.req_ready = req_ready_q;
  assign bus.req_err   = req_err_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_data_q;

  // Handshake qualifiers; a read fetch stops once the last beat sits in the output slot.
  always_comb begin
    addr_ok    = {1'b0, bus.req_addr} < ADDR_LIMIT;
    req_fire   = (state == ST_IDLE) && bus.req_valid && req_ready_q;
    req_take   = req_fire && addr_ok;
    wr_fire    = (state == ST_WRITE) && bus.wr_valid && wr_ready_q;
    rd_fire    = rd_valid_q && bus.rd_ready;
    final_beat = (cnt == len);
    fetch      = (state == ST_READ) && (!rd_valid_q || bus.rd_ready) && !(rd_valid_q && rd_last_q);
    addr_inc   = (addr == ADDR_LAST) ? '0 : addr + 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_take) state_nxt = bus.req_write ? ST_WRITE : ST_READ;
      ST_WRITE: if (wr_fire && final_beat) state_nxt = ST_IDLE;
      ST_READ:  if (rd_fire && rd_last_q) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt      = (state_nxt != ST_IDLE);
    wr_ready_nxt  = (state_nxt == ST_WRITE);
    req_err_nxt   = req_fire && !addr_ok;
    rd_valid_nxt  = rd_valid_q;
    rd_last_nxt   = rd_last_q;
    if (fetch) begin
      rd_valid_nxt = 1'b1;
      rd_last_nxt  = final_beat;
    end else if (rd_fire) begin
      rd_valid_nxt = 1'b0;
      rd_last_nxt  = 1'b0;
    end
  end

  // Output registers and burst bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_q <= 1'b0;
      req_err_q   <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      addr        <= '0;
      len         <= '0;
      cnt         <= '0;
      be          <= '0;
    end else begin
      req_ready_q <= req_ready_nxt;
      req_err_q   <= req_err_nxt;
      wr_ready_q  <= wr_ready_nxt;
      busy_q      <= busy_nxt;
      rd_valid_q  <= rd_valid_nxt;
      rd_last_q   <= rd_last_nxt;
      if (fetch) rd_data_q <= mem[addr];
      if (req_take) begin
        addr <= bus.req_addr;
        len  <= bus.req_len;
        be   <= bus.req_be;
        cnt  <= '0;
      end else if (wr_fire || fetch) begin
        addr <= addr_inc;
        cnt  <= cnt + 1'b1;
      end
    end
  end

  // Storage array is never cleared; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      for (int i = 0; i < int'(BE_WIDTH); i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed self-checking bench for sram_burst_ctrl (MEM_SIZE=200 to exercise non-power-of-two wrap).
module tb_sram_burst_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned MS = 200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  sram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] wdata    [16];
  logic [31:0] got_data [16];
  logic        got_last [16];
  int          got_n;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [7:0] a, input logic [3:0] l, input logic [3:0] be);
    int cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 50) begin step(); cyc++; end
    if (bus.req_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL req_ready_timeout got %b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_len = l; bus.req_be = be;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic write_beats(input int n);
    for (int i = 0; i < n; i++) begin
      int cyc = 0;
      bus.wr_data  = wdata[i];
      bus.wr_valid = 1'b1;
      while (bus.wr_ready !== 1'b1 && cyc < 50) begin step(); cyc++; end
      if (bus.wr_ready !== 1'b1) begin
        tests++; fails++;
        $display("FAIL wr_ready_timeout beat %0d got %b want 1", i, bus.wr_ready);
      end
      step();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] a, input logic [3:0] l, input logic [3:0] be);
    send_req(1'b1, a, l, be);
    write_beats(int'(l) + 1);
  endtask

  task automatic collect(input int n);
    int cyc = 0;
    got_n = 0;
    bus.rd_ready = 1'b1;
    while (got_n < n && cyc < 100) begin
      if (bus.rd_valid === 1'b1) begin
        got_data[got_n] = bus.rd_data;
        got_last[got_n] = bus.rd_last;
        got_n++;
      end
      step();
      cyc++;
    end
    bus.rd_ready = 1'b0;
    if (got_n != n) begin
      tests++; fails++;
      $display("FAIL rd_beat_timeout got %0d beats want %0d", got_n, n);
    end
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [3:0] l);
    send_req(1'b0, a, l, 4'h0);
    collect(int'(l) + 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
    tests++; if (bus.req_err !== 1'b0) begin fails++; $display("FAIL reset_req_err got %b want 0", bus.req_err); end
    tests++; if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL reset_wr_ready got %b want 0", bus.wr_ready); end
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
    tests++; if (bus.rd_last !== 1'b0) begin fails++; $display("FAIL reset_rd_last got %b want 0", bus.rd_last); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    tests++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
    reset = 1'b0;
    step();
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL idle_req_ready got %b want 1", bus.req_ready); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) wdata[i] = 32'hA0 + 32'(i);
    send_req(1'b1, 8'h10, 4'd3, 4'hF);
    tests++; if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b1) begin
      fails++; $display("FAIL write_busy got busy=%b wr_ready=%b want 1 1", bus.busy, bus.wr_ready);
    end
    write_beats(4);
    tests++; if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin
      fails++; $display("FAIL write_done got busy=%b wr_ready=%b want 0 0", bus.busy, bus.wr_ready);
    end
    send_req(1'b0, 8'h10, 4'd3, 4'h0);
    tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL read_latency_n1 got rd_valid=%b want 0", bus.rd_valid); end
    step();
    tests++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL read_latency_n2 got rd_valid=%b want 1", bus.rd_valid); end
    collect(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_data[i] !== 32'hA0 + 32'(i) || got_last[i] !== (i == 3)) begin
        fails++;
        $display("FAIL burst_beat%0d got %h last=%b want %h last=%b", i, got_data[i], got_last[i], 32'hA0 + 32'(i), (i == 3));
      end
    end
    tests++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
      fails++; $display("FAIL read_done got busy=%b rd_valid=%b want 0 0", bus.busy, bus.rd_valid);
    end
  endtask

  task automatic test_byte_enable();
    wdata[0] = 32'hFFFF_FFFF; write_burst(8'h20, 4'd0, 4'hF);
    wdata[0] = 32'h1234_5678; write_burst(8'h20, 4'd0, 4'b0101);
    read_burst(8'h20, 4'd0);
    tests++; if (got_data[0] !== 32'hFF34_FF78 || got_last[0] !== 1'b1) begin
      fails++; $display("FAIL byte_enable got %h last=%b want ff34ff78 last=1", got_data[0], got_last[0]);
    end
    wdata[0] = 32'h0; write_burst(8'h20, 4'd0, 4'h0);
    read_burst(8'h20, 4'd0);
    tests++; if (got_data[0] !== 32'hFF34_FF78) begin
      fails++; $display("FAIL be_zero got %h want ff34ff78", got_data[0]);
    end
  endtask

  task automatic test_stall();
    logic        pat [4];
    logic [31:0] held_d;
    logic        held_l;
    logic        pend = 1'b0;
    int          n = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    send_req(1'b0, 8'h10, 4'd3, 4'h0);
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      bus.rd_ready = pat[cyc % 4];
      if (bus.rd_valid === 1'b1) begin
        if (pend) begin
          tests++;
          if (bus.rd_data !== held_d || bus.rd_last !== held_l) begin
            fails++; $display("FAIL stall_hold got %h last=%b want %h last=%b", bus.rd_data, bus.rd_last, held_d, held_l);
          end
        end
        if (bus.rd_ready) begin
          got_data[n] = bus.rd_data; got_last[n] = bus.rd_last; n++; pend = 1'b0;
        end else begin
          held_d = bus.rd_data; held_l = bus.rd_last; pend = 1'b1;
        end
      end
      step();
    end
    bus.rd_ready = 1'b0;
    tests++; if (n != 4) begin fails++; $display("FAIL stall_count got %0d want 4", n); end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (got_data[i] !== 32'hA0 + 32'(i) || got_last[i] !== (i == 3)) begin
        fails++; $display("FAIL stall_beat%0d got %h last=%b want %h last=%b", i, got_data[i], got_last[i], 32'hA0 + 32'(i), (i == 3));
      end
    end
    step();
    tests++; if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL stall_extra got rd_valid=%b busy=%b want 0 0", bus.rd_valid, bus.busy);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) wdata[i] = 32'hD0 + 32'(i);
    write_burst(8'(MS - 1), 4'd2, 4'hF);
    read_burst(8'd0, 4'd1);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (got_data[i] !== 32'hD1 + 32'(i)) begin fails++; $display("FAIL wrap_low%0d got %h want %h", i, got_data[i], 32'hD1 + 32'(i)); end
    end
    read_burst(8'(MS - 1), 4'd2);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got_data[i] !== 32'hD0 + 32'(i)) begin fails++; $display("FAIL wrap_read%0d got %h want %h", i, got_data[i], 32'hD0 + 32'(i)); end
    end
  endtask

  task automatic test_req_err();
    int pulses = 0;
    int wr_seen = 0;
    bus.wr_valid = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    send_req(1'b1, 8'd210, 4'd0, 4'hF);
    tests++; if (bus.req_err !== 1'b1 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL req_err_pulse got req_err=%b busy=%b want 1 0", bus.req_err, bus.busy);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.req_err === 1'b1) pulses++;
      if (bus.wr_ready === 1'b1 || bus.busy === 1'b1) wr_seen++;
    end
    bus.wr_valid = 1'b0;
    tests++; if (pulses != 0) begin fails++; $display("FAIL req_err_once got %0d extra pulses want 0", pulses); end
    tests++; if (wr_seen != 0) begin fails++; $display("FAIL req_err_idle got %0d busy cycles want 0", wr_seen); end
    read_burst(8'h10, 4'd0);
    tests++; if (got_data[0] !== 32'hA0) begin fails++; $display("FAIL req_err_mem got %h want 000000a0", got_data[0]); end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 8; i++) wdata[i] = 32'hC0 + 32'(i);
    write_burst(8'h40, 4'd7, 4'hF);
    for (int i = 0; i < 8; i++) wdata[i] = 32'hB0 + 32'(i);
    send_req(1'b1, 8'h40, 4'd7, 4'hF);
    write_beats(2);
    bus.wr_data = wdata[2]; bus.wr_valid = 1'b1; reset = 1'b1;
    step();
    tests++;
    if (bus.req_ready !== 1'b0 || bus.req_err !== 1'b0 || bus.wr_ready !== 1'b0 || bus.busy !== 1'b0 ||
        bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.rd_data !== 32'h0) begin
      fails++;
      $display("FAIL midburst_reset got rr=%b re=%b wr=%b busy=%b rv=%b rl=%b rd=%h want all 0",
               bus.req_ready, bus.req_err, bus.wr_ready, bus.busy, bus.rd_valid, bus.rd_last, bus.rd_data);
    end
    reset = 1'b0; bus.wr_valid = 1'b0;
    step();
    read_burst(8'h40, 4'd7);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_d;
      exp_d = (i < 2) ? 32'hB0 + 32'(i) : 32'hC0 + 32'(i);
      tests++;
      if (got_data[i] !== exp_d) begin fails++; $display("FAIL midburst_word%0d got %h want %h", i, got_data[i], exp_d); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.req_be = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    test_reset();
    test_burst();
    test_byte_enable();
    test_stall();
    test_wrap();
    test_req_err();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
